fill_header_tx: RTL and testbench
=================================

FILL_HEADER_TX -- requirements
Module: fill_header_tx

Interface
REQ-001 Parameter HDR_ID, default 8'hA5, header identifier placed in word 0 bits [31:24].
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 fill_valid  input  1  fill-number FIFO has an entry.
REQ-005 fill_ready  output  1  block accepts the fill number this cycle.
REQ-006 fill_num  input  24  fill number offered with fill_valid.
REQ-007 hdr_data  output  32  header stream word.
REQ-008 hdr_valid  output  1  hdr_data valid.
REQ-009 hdr_ready  input  1  downstream accepts hdr_data.
REQ-010 hdr_last  output  1  marks final header word.
REQ-011 seq_err  output  1  sticky fill-number sequence error.
REQ-012 fills_sent  output  32  count of completed headers.

Function
REQ-013 State machine SHALL use states IDLE, W0, W1, W2 (plus W3 per REQ-030); fill_ready=1 only in IDLE; hdr_valid=1 only in W0..W3.
REQ-014 IDLE: on fill_valid&&fill_ready, latch fill_num, timestamp and skip flag, go to W0; otherwise hold.
REQ-015 Latency: first header word valid the cycle after fill acceptance.
REQ-016 Wn advances to next word state only on hdr_valid&&hdr_ready; otherwise hold state with hdr_data/hdr_last unchanged.
REQ-017 Word 0 = {HDR_ID, latched fill_num}.
REQ-018 Word 1 = 32-bit timestamp value in the acceptance cycle.
REQ-019 Word 2 = {skip flag, 7'b0, expected fill number in use at acceptance}.
REQ-020 Timestamp: free-running 32-bit counter, +1 every cycle, wraps FFFFFFFF->0.
REQ-021 Expected fill number: 1 after reset; on each acceptance becomes (fill_num+1) mod 2^24, so FFFFFF is followed by 000000 without error.
REQ-022 Skip flag = (fill_num != expected) at acceptance; seq_err set when skip flag set, held until reset.
REQ-023 hdr_last=1 only on final word; final-word acceptance returns to IDLE and increments fills_sent (wraps mod 2^32).
REQ-024 fill_ready is 0 while a header is in flight; back-to-back fills incur one IDLE cycle between headers.
REQ-025 fill_num and fill_valid ignored outside IDLE.

Reset
REQ-026 Reset SHALL force IDLE; fill_ready=1 on the first cycle after reset.
REQ-027 Reset values: hdr_valid=0, hdr_last=0, hdr_data=0, seq_err=0, fills_sent=0, timestamp=0, expected=1.
REQ-028 Reset mid-header SHALL abandon the header immediately; fills_sent not incremented.
REQ-029 Reset has priority over any simultaneous handshake.

Configuration
REQ-030 Macro FILL_HDR_CHECKSUM_EN defined: adds state W3 emitting word 3 = XOR of words 0..2, hdr_last on word 3 (4-word header).
REQ-031 FILL_HDR_CHECKSUM_EN undefined: W3 absent, hdr_last on word 2 (3-word header); all other behaviour identical.

Verification
REQ-032 After reset, fill_num=1 valid, hdr_ready=1 -> words A5000001, timestamp, 00000001; seq_err=0; fills_sent=1.
REQ-033 fill_num=5 when expected=2 -> word 2 = 80000002, seq_err=1 and stays 1 over later correct fills until reset.
REQ-034 Fills FFFFFF then 000000 -> second header word 2 = 00000000, seq_err unchanged.
REQ-035 hdr_ready low 3 cycles during word 1 -> hdr_data, hdr_last, hdr_valid stable, fill_ready=0 throughout.
REQ-036 Reset asserted during W1 -> next cycle IDLE, hdr_valid=0, fill_ready=1, fills_sent unchanged, expected=1.
REQ-037 With FILL_HDR_CHECKSUM_EN, fill_num=1 latched at timestamp 10 -> word 3 = A5000001^0000000A^00000001 = A500000A, hdr_last only on word 3.

Source files
------------

// File: rtl/fill_header_tx.sv
// fill_header_tx: turns each accepted fill number into a header word stream.
// 3 words by default; defining FILL_HDR_CHECKSUM_EN adds an XOR checksum word.
module fill_header_tx #(
    parameter logic [7:0] HDR_ID = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fill_valid,
    output logic        fill_ready,
    input  logic [23:0] fill_num,
    output logic [31:0] hdr_data,
    output logic        hdr_valid,
    input  logic        hdr_ready,
    output logic        hdr_last,
    output logic        seq_err,
    output logic [31:0] fills_sent
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned FILL_W = 24;

`ifdef FILL_HDR_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, W0, W1, W2, W3} state_t;
`else
    typedef enum logic [1:0] {IDLE, W0, W1, W2} state_t;
`endif

    state_t state;
    state_t state_nx;

    logic [DATA_W-1:0] timestamp;
    logic [FILL_W-1:0] expected;

    // Fields captured at acceptance, used to build words 1..3
    logic [DATA_W-1:0] ts_q;
    logic [FILL_W-1:0] exp_q;
    logic              skip_q;
`ifdef FILL_HDR_CHECKSUM_EN
    logic [FILL_W-1:0] fill_q;
`endif

    logic [DATA_W-1:0] word1_c;
    logic [DATA_W-1:0] word2_c;
`ifdef FILL_HDR_CHECKSUM_EN
    logic [DATA_W-1:0] word0_c;
    logic [DATA_W-1:0] word3_c;
`endif

    logic              accept;
    logic              done;
    logic              skip_c;
    logic              fill_ready_nx;
    logic              hdr_valid_nx;
    logic              hdr_last_nx;
    logic [DATA_W-1:0] hdr_data_nx;

    assign skip_c  = (fill_num != expected);
    assign word1_c = ts_q;
    assign word2_c = {skip_q, 7'b0, exp_q};
`ifdef FILL_HDR_CHECKSUM_EN
    assign word0_c = {HDR_ID, fill_q};
    assign word3_c = word0_c ^ word1_c ^ word2_c;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and next output values; a stalled word holds everything
    always_comb begin
        state_nx     = state;
        hdr_valid_nx = hdr_valid;
        hdr_last_nx  = hdr_last;
        hdr_data_nx  = hdr_data;
        accept       = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (fill_valid && fill_ready) begin
                    accept       = 1'b1;
                    state_nx     = W0;
                    hdr_valid_nx = 1'b1;
                    hdr_last_nx  = 1'b0;
                    hdr_data_nx  = {HDR_ID, fill_num};
                end
            end
            W0: begin
                if (hdr_valid && hdr_ready) begin
                    state_nx    = W1;
                    hdr_data_nx = word1_c;
                end
            end
            W1: begin
                if (hdr_valid && hdr_ready) begin
                    state_nx    = W2;
                    hdr_data_nx = word2_c;
`ifndef FILL_HDR_CHECKSUM_EN
                    hdr_last_nx = 1'b1;
`endif
                end
            end
            W2: begin
                if (hdr_valid && hdr_ready) begin
`ifdef FILL_HDR_CHECKSUM_EN
                    state_nx    = W3;
                    hdr_data_nx = word3_c;
                    hdr_last_nx = 1'b1;
`else
                    state_nx     = IDLE;
                    hdr_valid_nx = 1'b0;
                    hdr_last_nx  = 1'b0;
                    done         = 1'b1;
`endif
                end
            end
`ifdef FILL_HDR_CHECKSUM_EN
            W3: begin
                if (hdr_valid && hdr_ready) begin
                    state_nx     = IDLE;
                    hdr_valid_nx = 1'b0;
                    hdr_last_nx  = 1'b0;
                    done         = 1'b1;
                end
            end
`endif
            default: begin
                state_nx     = IDLE;
                hdr_valid_nx = 1'b0;
                hdr_last_nx  = 1'b0;
            end
        endcase
        fill_ready_nx = (state_nx == IDLE);
    end

    // Registered outputs, timestamp, sequence tracking and capture fields
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_ready <= 1'b1;
            hdr_valid  <= 1'b0;
            hdr_last   <= 1'b0;
            hdr_data   <= '0;
            seq_err    <= 1'b0;
            fills_sent <= '0;
            timestamp  <= '0;
            expected   <= FILL_W'(1);
            ts_q       <= '0;
            exp_q      <= '0;
            skip_q     <= 1'b0;
`ifdef FILL_HDR_CHECKSUM_EN
            fill_q     <= '0;
`endif
        end else begin
            fill_ready <= fill_ready_nx;
            hdr_valid  <= hdr_valid_nx;
            hdr_last   <= hdr_last_nx;
            hdr_data   <= hdr_data_nx;
            timestamp  <= timestamp + DATA_W'(1);
            if (accept) begin
                ts_q     <= timestamp;
                exp_q    <= expected;
                skip_q   <= skip_c;
                expected <= fill_num + FILL_W'(1);
`ifdef FILL_HDR_CHECKSUM_EN
                fill_q   <= fill_num;
`endif
                if (skip_c) begin
                    seq_err <= 1'b1;
                end
            end
            if (done) begin
                fills_sent <= fills_sent + DATA_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fill_header_tx.sv
// Bench for fill_header_tx: directed scenarios plus random traffic checked
// cycle by cycle against a transaction-level header model.
module tb_fill_header_tx;
`ifdef FILL_HDR_CHECKSUM_EN
    localparam int HDR_WORDS = 4;
`else
    localparam int HDR_WORDS = 3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        fill_valid;
    logic        fill_ready;
    logic [23:0] fill_num;
    logic [31:0] hdr_data;
    logic        hdr_valid;
    logic        hdr_ready;
    logic        hdr_last;
    logic        seq_err;
    logic [31:0] fills_sent;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: one header is a list of words plus a read position
    bit          m_busy;
    int          m_idx;
    logic [31:0] m_words [4];
    logic [31:0] m_ts;
    logic [23:0] m_exp;
    bit          m_err;
    logic [31:0] m_sent;

    logic [31:0] seen [$];

    always #5 clk = ~clk;

    fill_header_tx dut (
        .clk        (clk),
        .reset      (reset),
        .fill_valid (fill_valid),
        .fill_ready (fill_ready),
        .fill_num   (fill_num),
        .hdr_data   (hdr_data),
        .hdr_valid  (hdr_valid),
        .hdr_ready  (hdr_ready),
        .hdr_last   (hdr_last),
        .seq_err    (seq_err),
        .fills_sent (fills_sent)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare
    task automatic cycle();
        bit          r;
        bit          v;
        bit          rd;
        bit          skip;
        logic [23:0] fn;
        r  = reset;
        v  = fill_valid;
        rd = hdr_ready;
        fn = fill_num;
        if (hdr_valid === 1'b1 && rd) seen.push_back(hdr_data);
        @(posedge clk);
        if (r) begin
            m_busy = 1'b0;
            m_idx  = 0;
            m_ts   = 32'd0;
            m_exp  = 24'd1;
            m_err  = 1'b0;
            m_sent = 32'd0;
        end else begin
            if (!m_busy) begin
                if (v) begin
                    skip       = (fn != m_exp);
                    m_words[0] = {8'hA5, fn};
                    m_words[1] = m_ts;
                    m_words[2] = {skip, 7'b0, m_exp};
                    m_words[3] = m_words[0] ^ m_words[1] ^ m_words[2];
                    m_err      = m_err | skip;
                    m_exp      = fn + 24'd1;
                    m_busy     = 1'b1;
                    m_idx      = 0;
                end
            end else if (rd) begin
                if (m_idx == HDR_WORDS - 1) begin
                    m_busy = 1'b0;
                    m_sent = m_sent + 32'd1;
                end else begin
                    m_idx++;
                end
            end
            m_ts = m_ts + 32'd1;
        end
        #1;
        chk("fill_ready", 32'(fill_ready), 32'(!m_busy));
        chk("hdr_valid", 32'(hdr_valid), 32'(m_busy));
        chk("hdr_last", 32'(hdr_last), 32'(m_busy && m_idx == HDR_WORDS - 1));
        chk("seq_err", 32'(seq_err), 32'(m_err));
        chk("fills_sent", fills_sent, m_sent);
        if (m_busy) chk("hdr_data", hdr_data, m_words[m_idx]);
    endtask

    task automatic do_reset(input int n);
        reset      = 1'b1;
        fill_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
        reset = 1'b0;
    endtask

    // Offer one fill and drain its header with hdr_ready held high
    task automatic send(input logic [23:0] fn);
        int n;
        hdr_ready = 1'b1;
        n = 0;
        while (m_busy && n < 20) begin cycle(); n++; end
        seen.delete();
        fill_valid = 1'b1;
        fill_num   = fn;
        cycle();
        fill_valid = 1'b0;
        fill_num   = 24'($urandom);
        n = 0;
        while (m_busy && n < 20) begin cycle(); n++; end
        chk("send_drained", 32'(fill_ready), 32'd1);
        chk("send_word_count", 32'(seen.size()), 32'(HDR_WORDS));
    endtask

    initial begin
        logic [31:0] held_data;
        logic        held_last;
        int          n;

        reset      = 1'b1;
        fill_valid = 1'b0;
        fill_num   = 24'd0;
        hdr_ready  = 1'b0;

        do_reset(3);
        chk("rst_hdr_data", hdr_data, 32'd0);

        // First fill after reset is in sequence
        send(24'd1);
        if (seen.size() == HDR_WORDS) begin
            chk("w0_first", seen[0], 32'hA500_0001);
            chk("w2_first", seen[2], 32'h0000_0001);
        end
        chk("first_err", 32'(seq_err), 32'd0);
        chk("first_sent", fills_sent, 32'd1);

        // Out-of-sequence fill sets sticky seq_err
        send(24'd5);
        if (seen.size() == HDR_WORDS) chk("w2_skip", seen[2], 32'h8000_0002);
        send(24'd6);
        send(24'd7);
        chk("err_sticky", 32'(seq_err), 32'd1);

        // Expected-number wrap from FFFFFF to 000000
        do_reset(2);
        send(24'hFF_FFFF);
        if (seen.size() == HDR_WORDS) chk("w2_ffffff", seen[2], 32'h8000_0001);
        send(24'h00_0000);
        if (seen.size() == HDR_WORDS) chk("w2_wrap", seen[2], 32'h0000_0000);
        chk("wrap_err", 32'(seq_err), 32'd1);

        // Stall during word 1, with fills offered and ignored, then reset in W1
        do_reset(2);
        hdr_ready  = 1'b1;
        fill_valid = 1'b1;
        fill_num   = 24'd1;
        cycle();
        cycle();
        hdr_ready = 1'b0;
        held_data = hdr_data;
        held_last = hdr_last;
        for (int i = 0; i < 3; i++) begin
            fill_num = 24'($urandom);
            cycle();
            chk("stall_data", hdr_data, held_data);
            chk("stall_last", 32'(hdr_last), 32'(held_last));
            chk("stall_valid", 32'(hdr_valid), 32'd1);
            chk("stall_ready", 32'(fill_ready), 32'd0);
        end
        fill_valid = 1'b0;
        hdr_ready  = 1'b1;
        do_reset(1);
        chk("w1rst_valid", 32'(hdr_valid), 32'd0);
        chk("w1rst_ready", 32'(fill_ready), 32'd1);
        chk("w1rst_sent", fills_sent, 32'd0);
        send(24'd1);
        if (seen.size() == HDR_WORDS) chk("w1rst_w2", seen[2], 32'h0000_0001);
        chk("w1rst_err", 32'(seq_err), 32'd0);

        // Reset wins over a simultaneous fill handshake
        reset      = 1'b1;
        fill_valid = 1'b1;
        fill_num   = 24'd1;
        cycle();
        reset      = 1'b0;
        fill_valid = 1'b0;
        chk("rstprio_valid", 32'(hdr_valid), 32'd0);
        chk("rstprio_ready", 32'(fill_ready), 32'd1);

`ifdef FILL_HDR_CHECKSUM_EN
        // Checksum word for fill 1 accepted at timestamp 10
        do_reset(1);
        n = 0;
        while (m_ts != 32'd10 && n < 20) begin cycle(); n++; end
        send(24'd1);
        if (seen.size() == HDR_WORDS) begin
            chk("w1_ts10", seen[1], 32'h0000_000A);
            chk("w3_checksum", seen[3], 32'hA500_000A);
        end
`endif

        // Random traffic, mostly in-sequence fills, occasional resets
        do_reset(1);
        for (int i = 0; i < 1500; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            fill_valid = ($urandom_range(0, 2) != 0);
            fill_num   = ($urandom_range(0, 6) == 0) ? 24'($urandom) : m_exp;
            if ($urandom_range(0, 40) == 0) fill_num = 24'hFF_FFFF;
            hdr_ready  = ($urandom_range(0, 3) != 0);
            cycle();
        end
        reset      = 1'b0;
        fill_valid = 1'b0;
        hdr_ready  = 1'b1;
        n = 0;
        while (m_busy && n < 20) begin cycle(); n++; end
        chk("final_idle", 32'(fill_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
